// File: rtl/multicycle_control_fsm.sv
// Multicycle RV32I control unit: one FSM sequences fetch/decode/execute/memory/writeback
// and drives the shared datapath selects, write enables, trap flag and retired counter.
module multicycle_control_fsm #(
   parameter int ALU_CTRL_W    = 3,
   parameter int MEM_HANDSHAKE = 1,
   parameter int SUPPORT_BNE   = 1,
   parameter int PERF_CNT_W    = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic [6:0]            op_i,
   input  logic [2:0]            funct3_i,
   input  logic                  funct7_b5_i,
   input  logic                  zero_i,
   input  logic                  mem_ready_i,
   output logic                  mem_req_o,
   output logic                  mem_write_o,
   output logic                  adr_src_o,
   output logic                  ir_write_o,
   output logic                  pc_write_o,
   output logic [1:0]            alu_src_a_o,
   output logic [1:0]            alu_src_b_o,
   output logic [ALU_CTRL_W-1:0] alu_control_o,
   output logic [1:0]            imm_src_o,
   output logic [1:0]            result_src_o,
   output logic                  reg_write_o,
   output logic                  byte_address_o,
   output logic                  illegal_o,
   output logic [PERF_CNT_W-1:0] retired_cnt_o
);

   typedef enum logic [3:0] {
      FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
      EXECR, EXECI, ALUWB, JAL, BRANCH, TRAP
   } state_t;

   state_t                state, state_nxt;
   logic                  ready, retire, bne_sel;
   logic [2:0]            funct_alu;
   logic [PERF_CNT_W-1:0] retired_cnt;

   assign ready   = (MEM_HANDSHAKE != 0) ? mem_ready_i : 1'b1;
   assign bne_sel = (SUPPORT_BNE != 0) && (funct3_i == 3'b001);

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state       <= FETCH;
         retired_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (retire) retired_cnt <= retired_cnt + PERF_CNT_W'(1);
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         FETCH:    if (ready) state_nxt = DECODE;
         DECODE: begin
            case (op_i)
               7'b0000011, 7'b0100011: state_nxt = MEMADR;
               7'b0110011:             state_nxt = EXECR;
               7'b0010011:             state_nxt = EXECI;
               7'b1101111:             state_nxt = JAL;
               7'b1100011:             state_nxt = BRANCH;
               default:                state_nxt = TRAP;
            endcase
         end
         MEMADR:   state_nxt = op_i[5] ? MEMWRITE : MEMREAD;
         MEMREAD:  if (ready) state_nxt = MEMWB;
         MEMWB:    state_nxt = FETCH;
         MEMWRITE: if (ready) state_nxt = FETCH;
         EXECR:    state_nxt = ALUWB;
         EXECI:    state_nxt = ALUWB;
         ALUWB:    state_nxt = FETCH;
         JAL:      state_nxt = ALUWB;
         BRANCH:   state_nxt = FETCH;
         TRAP:     state_nxt = TRAP;
         default:  state_nxt = FETCH;
      endcase
   end

   // Any transition back into FETCH from a terminal state retires the instruction.
   always_comb begin
      retire = 1'b0;
      case (state)
         MEMWB, ALUWB, BRANCH: retire = 1'b1;
         MEMWRITE:             retire = ready;
         default:              retire = 1'b0;
      endcase
   end

   // Only R-type (op[5]=1) may select sub; addi with instr[30] set stays add.
   always_comb begin
      funct_alu = 3'b000;
      case (funct3_i)
         3'b000:  if (funct7_b5_i && op_i[5]) funct_alu = 3'b001;
         3'b010:  funct_alu = 3'b101;
         3'b100:  funct_alu = 3'b100;
         3'b110:  funct_alu = 3'b011;
         3'b111:  funct_alu = 3'b010;
         default: funct_alu = 3'b000;
      endcase
   end

   always_comb begin
      mem_req_o      = 1'b0;
      mem_write_o    = 1'b0;
      adr_src_o      = 1'b0;
      ir_write_o     = 1'b0;
      pc_write_o     = 1'b0;
      alu_src_a_o    = 2'b00;
      alu_src_b_o    = 2'b00;
      alu_control_o  = '0;
      imm_src_o      = 2'b00;
      result_src_o   = 2'b00;
      reg_write_o    = 1'b0;
      byte_address_o = 1'b0;
      illegal_o      = 1'b0;
      retired_cnt_o  = '0;
      if (rst_n_i) begin
         retired_cnt_o = retired_cnt;
         case (op_i)
            7'b0100011: imm_src_o = 2'b01;
            7'b1100011: imm_src_o = 2'b10;
            7'b1101111: imm_src_o = 2'b11;
            default:    imm_src_o = 2'b00;
         endcase
         case (state)
            FETCH: begin
               mem_req_o    = 1'b1;
               alu_src_b_o  = 2'b10;
               result_src_o = 2'b10;
               ir_write_o   = ready;
               pc_write_o   = ready;
            end
            DECODE: begin
               alu_src_a_o = 2'b01;
               alu_src_b_o = 2'b01;
            end
            MEMADR: begin
               alu_src_a_o = 2'b10;
               alu_src_b_o = 2'b01;
            end
            MEMREAD: begin
               mem_req_o      = 1'b1;
               adr_src_o      = 1'b1;
               byte_address_o = (funct3_i == 3'b000);
            end
            MEMWB: begin
               result_src_o   = 2'b01;
               reg_write_o    = 1'b1;
               byte_address_o = (funct3_i == 3'b000);
            end
            MEMWRITE: begin
               mem_req_o      = 1'b1;
               mem_write_o    = 1'b1;
               adr_src_o      = 1'b1;
               byte_address_o = (funct3_i == 3'b000);
            end
            EXECR: begin
               alu_src_a_o   = 2'b10;
               alu_control_o = ALU_CTRL_W'(funct_alu);
            end
            EXECI: begin
               alu_src_a_o   = 2'b10;
               alu_src_b_o   = 2'b01;
               alu_control_o = ALU_CTRL_W'(funct_alu);
            end
            ALUWB: reg_write_o = 1'b1;
            JAL: begin
               alu_src_a_o = 2'b01;
               alu_src_b_o = 2'b10;
               pc_write_o  = 1'b1;
            end
            BRANCH: begin
               alu_src_a_o   = 2'b10;
               alu_control_o = ALU_CTRL_W'(3'b001);
               pc_write_o    = zero_i ^ bne_sel;
            end
            TRAP:    illegal_o = 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: two configurations driven by per-instruction phase plans,
// each cycle checked against a control word built from the phase/instruction rules.
module tb_multicycle_control_fsm;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic       rst_n;
      logic [6:0] op;
      logic [2:0] f3;
      logic       f7;
      logic       zero;
      logic       ready;
   } in_t;

   typedef struct packed {
      logic       req, wr, adr, irw, pcw;
      logic [1:0] sa, sb;
      logic [2:0] alu;
      logic [1:0] imm, res;
      logic       rw, byt, ill;
   } ctl_t;

   typedef enum int {PF, PD, PMA, PMR, PMWB, PMW, PER, PEI, PAWB, PJ, PBR, PT} ph_t;

   // dut 0: handshake on, BNE on, 32-bit counter; dut 1: handshake off, BEQ only, 4-bit counter
   localparam bit HS[2]  = '{1'b1, 1'b0};
   localparam bit BNE[2] = '{1'b1, 1'b0};
   localparam logic [31:0] MASK[2] = '{32'hffff_ffff, 32'h0000_000f};

   in_t         din [2];
   ctl_t        dout[2];
   logic [31:0] cnt_o[2];
   logic [31:0] exp_cnt[2];
   ph_t         plan[$];
   int          n_chk = 0, n_fail = 0;

   localparam logic [6:0] LEGAL[6] = '{7'b0000011, 7'b0100011, 7'b0110011,
                                       7'b0010011, 7'b1101111, 7'b1100011};

   for (genvar g = 0; g < 2; g++) begin : g_dut
      localparam int CW = (g == 0) ? 32 : 4;
      logic            req, wr, adr, irw, pcw, rw, byt, ill;
      logic [1:0]      sa, sb, imm, res;
      logic [2:0]      alu;
      logic [CW-1:0]   cnt;
      multicycle_control_fsm #(
         .ALU_CTRL_W(3), .MEM_HANDSHAKE(HS[g] ? 1 : 0),
         .SUPPORT_BNE(BNE[g] ? 1 : 0), .PERF_CNT_W(CW)
      ) u_dut (
         .clk_i(clk), .rst_n_i(din[g].rst_n), .op_i(din[g].op), .funct3_i(din[g].f3),
         .funct7_b5_i(din[g].f7), .zero_i(din[g].zero), .mem_ready_i(din[g].ready),
         .mem_req_o(req), .mem_write_o(wr), .adr_src_o(adr), .ir_write_o(irw),
         .pc_write_o(pcw), .alu_src_a_o(sa), .alu_src_b_o(sb), .alu_control_o(alu),
         .imm_src_o(imm), .result_src_o(res), .reg_write_o(rw), .byte_address_o(byt),
         .illegal_o(ill), .retired_cnt_o(cnt)
      );
      assign dout[g]  = {req, wr, adr, irw, pcw, sa, sb, alu, imm, res, rw, byt, ill};
      assign cnt_o[g] = 32'(cnt);
   end

   function automatic bit is_legal(input logic [6:0] op);
      foreach (LEGAL[j]) if (LEGAL[j] == op) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [2:0] fdec(input in_t i);
      case (i.f3)
         3'b000:  return (i.f7 && i.op[5]) ? 3'b001 : 3'b000;
         3'b010:  return 3'b101;
         3'b100:  return 3'b100;
         3'b110:  return 3'b011;
         3'b111:  return 3'b010;
         default: return 3'b000;
      endcase
   endfunction

   // Expected control word for one cycle of phase p of the current instruction.
   function automatic ctl_t exp_ctl(input int k, input ph_t p, input in_t i);
      ctl_t c   = '0;
      bit   rdy = HS[k] ? i.ready : 1'b1;
      bit   sb_ = (i.f3 == 3'b000);
      case (i.op)
         7'b0100011: c.imm = 2'b01;
         7'b1100011: c.imm = 2'b10;
         7'b1101111: c.imm = 2'b11;
         default:    c.imm = 2'b00;
      endcase
      case (p)
         PF:   begin c.req = 1; c.sb = 2'b10; c.res = 2'b10; c.irw = rdy; c.pcw = rdy; end
         PD:   begin c.sa = 2'b01; c.sb = 2'b01; end
         PMA:  begin c.sa = 2'b10; c.sb = 2'b01; end
         PMR:  begin c.req = 1; c.adr = 1; c.byt = sb_; end
         PMWB: begin c.res = 2'b01; c.rw = 1; c.byt = sb_; end
         PMW:  begin c.req = 1; c.wr = 1; c.adr = 1; c.byt = sb_; end
         PER:  begin c.sa = 2'b10; c.alu = fdec(i); end
         PEI:  begin c.sa = 2'b10; c.sb = 2'b01; c.alu = fdec(i); end
         PAWB: c.rw = 1;
         PJ:   begin c.sa = 2'b01; c.sb = 2'b10; c.pcw = 1; end
         PBR:  begin c.sa = 2'b10; c.alu = 3'b001; c.pcw = i.zero ^ (BNE[k] && i.f3 == 3'b001); end
         PT:   c.ill = 1;
         default: ;
      endcase
      return c;
   endfunction

   task automatic cycle_check(input int k, input ph_t p, input in_t i);
      ctl_t e;
      @(negedge clk);
      i.rst_n = 1'b1;
      din[k]  = i;
      #1;
      e = exp_ctl(k, p, i);
      n_chk++;
      if (dout[k] !== e) begin
         n_fail++;
         $display("FAIL ctl dut%0d phase %s op=%b: got %h want %h", k, p.name(), i.op, dout[k], e);
      end
      n_chk++;
      if (cnt_o[k] !== exp_cnt[k]) begin
         n_fail++;
         $display("FAIL retired_cnt dut%0d phase %s: got %0d want %0d", k, p.name(), cnt_o[k], exp_cnt[k]);
      end
   endtask

   // Runs one instruction; fw/mw are ready-low cycles inserted in fetch and data memory phases.
   task automatic run_instr(input int k, input logic [6:0] op, input logic [2:0] f3,
                            input logic f7, input logic z, input int fw, input int mw);
      in_t i = '{rst_n: 1'b1, op: op, f3: f3, f7: f7, zero: z, ready: 1'b1};
      int  nw;
      plan.delete();
      case (op)
         7'b0000011: plan = '{PF, PD, PMA, PMR, PMWB};
         7'b0100011: plan = '{PF, PD, PMA, PMW};
         7'b0110011: plan = '{PF, PD, PER, PAWB};
         7'b0010011: plan = '{PF, PD, PEI, PAWB};
         7'b1101111: plan = '{PF, PD, PJ, PAWB};
         7'b1100011: plan = '{PF, PD, PBR};
         default:    plan = '{PF, PD, PT, PT, PT, PT};
      endcase
      foreach (plan[j]) begin
         nw = (HS[k] && (plan[j] == PF || plan[j] == PMR || plan[j] == PMW)) ?
              ((plan[j] == PF) ? fw : mw) : 0;
         for (int c = 0; c <= nw; c++) begin
            i.ready = (c == nw);
            if (!HS[k]) i.ready = 1'($urandom);
            cycle_check(k, plan[j], i);
         end
      end
      if (is_legal(op)) exp_cnt[k] = (exp_cnt[k] + 32'd1) & MASK[k];
   endtask

   task automatic rand_instr(input int k);
      run_instr(k, LEGAL[$urandom_range(0, 5)], 3'($urandom), 1'($urandom), 1'($urandom),
                $urandom_range(0, 2), $urandom_range(0, 3));
   endtask

   // Resets both DUTs for one edge, then releases only dut k; the other stays in reset.
   task automatic do_reset(input int k);
      @(negedge clk);
      din[0].rst_n = 1'b0;
      din[1].rst_n = 1'b0;
      din[k].op    = 7'($urandom);
      din[k].ready = 1'($urandom);
      #1;
      for (int j = 0; j < 2; j++) begin
         n_chk++;
         if (dout[j] !== '0 || cnt_o[j] !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_outputs dut%0d: got ctl %h cnt %0d want all 0", j, dout[j], cnt_o[j]);
         end
      end
      @(posedge clk);
      #1;
      exp_cnt[k]   = 32'd0;
      din[k].rst_n = 1'b1;
   endtask

   task automatic check_cnt(input string name, input int k, input logic [31:0] want);
      @(posedge clk);
      #1;
      n_chk++;
      if (cnt_o[k] !== want) begin
         n_fail++;
         $display("FAIL %s dut%0d: got %0d want %0d", name, k, cnt_o[k], want);
      end
   endtask

   task automatic test_reset();
      in_t i = '{rst_n: 1'b1, op: 7'b0110011, f3: 3'b0, f7: 1'b0, zero: 1'b0, ready: 1'b0};
      do_reset(0);
      cycle_check(0, PF, i);
   endtask

   task automatic test_add();
      do_reset(0);
      run_instr(0, 7'b0110011, 3'b000, 1'b0, 1'b0, 0, 0);
      check_cnt("add_retired", 0, 32'd1);
      run_instr(0, 7'b0110011, 3'b000, 1'b1, 1'b0, 0, 0);
   endtask

   task automatic test_load_store();
      run_instr(0, 7'b0000011, 3'b010, 1'b0, 1'b0, 0, 3);
      run_instr(0, 7'b0100011, 3'b000, 1'b0, 1'b0, 1, 2);
      run_instr(0, 7'b0000011, 3'b000, 1'b0, 1'b0, 2, 0);
      check_cnt("ld_st_retired", 0, 32'd5);
   endtask

   task automatic test_branch();
      run_instr(0, 7'b1100011, 3'b000, 1'b0, 1'b1, 0, 0);
      run_instr(0, 7'b1100011, 3'b001, 1'b0, 1'b1, 0, 0);
      run_instr(0, 7'b1100011, 3'b001, 1'b0, 1'b0, 0, 0);
      run_instr(0, 7'b1101111, 3'b000, 1'b0, 1'b0, 0, 0);
      do_reset(1);
      run_instr(1, 7'b1100011, 3'b001, 1'b0, 1'b1, 0, 0);
      run_instr(1, 7'b1100011, 3'b000, 1'b0, 1'b0, 0, 0);
   endtask

   task automatic test_trap();
      logic [6:0] op;
      in_t        i = '{rst_n: 1'b1, op: 7'b0, f3: 3'b0, f7: 1'b0, zero: 1'b0, ready: 1'b1};
      do_reset(0);
      rand_instr(0);
      run_instr(0, 7'b0000000, 3'b000, 1'b0, 1'b0, 0, 0);
      do_reset(0);
      cycle_check(0, PF, i);
      do_reset(1);
      do op = 7'($urandom); while (is_legal(op));
      run_instr(1, op, 3'($urandom), 1'b0, 1'b0, 0, 0);
   endtask

   task automatic test_cnt_wrap();
      do_reset(1);
      repeat (15) rand_instr(1);
      check_cnt("cnt_full", 1, 32'd15);
      rand_instr(1);
      check_cnt("cnt_wrap", 1, 32'd0);
   endtask

   task automatic test_reset_mid_store();
      in_t i = '{rst_n: 1'b1, op: 7'b0100011, f3: 3'b000, f7: 1'b0, zero: 1'b0, ready: 1'b1};
      do_reset(0);
      cycle_check(0, PF, i);
      cycle_check(0, PD, i);
      cycle_check(0, PMA, i);
      i.ready = 1'b0;
      cycle_check(0, PMW, i);
      cycle_check(0, PMW, i);
      @(negedge clk);
      din[0].rst_n = 1'b0;
      din[0].ready = 1'b1;
      #1;
      n_chk++;
      if (dout[0] !== '0) begin
         n_fail++;
         $display("FAIL reset_mid_store: got ctl %h want 0", dout[0]);
      end
      @(posedge clk);
      #1;
      din[0].rst_n = 1'b1;
      exp_cnt[0]   = 32'd0;
      i.ready = 1'b0;
      cycle_check(0, PF, i);
      cycle_check(0, PF, i);
      i.ready = 1'b1;
      cycle_check(0, PF, i);
      cycle_check(0, PD, i);
   endtask

   task automatic test_random();
      for (int k = 0; k < 2; k++) begin
         do_reset(k);
         repeat (40) rand_instr(k);
         check_cnt("random_retired", k, 32'd40 & MASK[k]);
      end
   endtask

   initial begin
      din[0]     = '0;
      din[1]     = '0;
      exp_cnt[0] = 32'd0;
      exp_cnt[1] = 32'd0;
      repeat (2) @(posedge clk);
      test_reset();
      test_add();
      test_load_store();
      test_branch();
      test_trap();
      test_cnt_wrap();
      test_reset_mid_store();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
